// File: rtl/mul_div_pkg.sv
// Shared binary32 definitions for the mul_div datapath: field widths, special
// encodings, the packed float struct and an operand classifier.
package mul_div_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_t;

   // Subnormals classify as zero so they are flushed before any arithmetic.
   function automatic fp_class_t fp_class(input fp32_t f);
      fp_class_t cls;
      if (f.exp == 8'd0) begin
         cls = CLS_ZERO;
      end else if (f.exp == 8'hFF) begin
         cls = (f.frac == 23'd0) ? CLS_INF : CLS_NAN;
      end else begin
         cls = CLS_NORM;
      end
      return cls;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack for a normalised 24-bit mantissa; saturates
// to infinity on overflow and flushes to signed zero on underflow.
module fp_round_pack
   import mul_div_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] exp_unb,
   input  logic [23:0]       mant,
   input  logic              guard,
   input  logic              sticky,
   output fp32_t             res,
   output logic              overflow,
   output logic              underflow
);

   logic               round_up_s;
   logic [24:0]        mant_rnd_s;
   logic [22:0]        frac_s;
   logic signed [10:0] exp_b_s;

   // Round, renormalise on mantissa carry, then range-check the biased exponent.
   always_comb begin
      round_up_s = guard & (sticky | mant[0]);
      mant_rnd_s = {1'b0, mant} + {24'd0, round_up_s};
      // On carry the rounded mantissa is exactly 2.0, so bits [23:1] are zero.
      frac_s     = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];
      exp_b_s    = {exp_unb[9], exp_unb} + 11'd127 + {10'd0, mant_rnd_s[24]};
      overflow   = 1'b0;
      underflow  = 1'b0;
      if (exp_b_s >= 11'sd255) begin
         res      = {sign, 8'hFF, 23'd0};
         overflow = 1'b1;
      end else if (exp_b_s < 11'sd1) begin
         res       = {sign, 31'd0};
         underflow = 1'b1;
      end else begin
         res = {sign, exp_b_s[7:0], frac_s};
      end
   end

endmodule

// File: rtl/mul_div.sv
// Two-stage binary32 multiply/divide: operands are captured on the first edge,
// the result and exception flags are computed and registered on the second.
module mul_div
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             overflow,
   output logic             underflow,
   output logic             invalid,
   output logic             div_zero
);

   fp32_t a_r;
   fp32_t b_r;
   logic  op_r;
   logic  v_r;

   fp_class_t         cls_a_s;
   fp_class_t         cls_b_s;
   logic              sign_s;
   logic [23:0]       ma_s;
   logic [23:0]       mb_s;
   logic [47:0]       prod_s;
   logic [49:0]       num_s;
   logic [49:0]       den_s;
   logic [26:0]       quo_s;
   logic [23:0]       rem_s;
   logic signed [9:0] exp_a_s;
   logic signed [9:0] exp_b_s;

   logic signed [9:0] rp_exp_s;
   logic [23:0]       rp_mant_s;
   logic              rp_guard_s;
   logic              rp_sticky_s;
   fp32_t             rp_res_s;
   logic              rp_ovf_s;
   logic              rp_unf_s;

   fp32_t res_s;
   logic  ovf_s;
   logic  unf_s;
   logic  inv_s;
   logic  dz_s;

   // Input stage: capture operands on accepted cycles, valid follows in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r  <= 32'd0;
         b_r  <= 32'd0;
         op_r <= 1'b0;
         v_r  <= 1'b0;
      end else begin
         v_r <= in_valid;
         if (in_valid) begin
            a_r  <= op_a;
            b_r  <= op_b;
            op_r <= op_sel;
         end
      end
   end

   assign cls_a_s = fp_class(a_r);
   assign cls_b_s = fp_class(b_r);
   assign sign_s  = a_r.sign ^ b_r.sign;
   assign ma_s    = {1'b1, a_r.frac};
   assign mb_s    = {1'b1, b_r.frac};
   assign prod_s  = {24'd0, ma_s} * {24'd0, mb_s};
   // Dividend scaled so the quotient always carries 26 or 27 significant bits.
   assign num_s   = {ma_s, 26'd0};
   assign den_s   = {26'd0, mb_s};
   assign quo_s   = 27'(num_s / den_s);
   assign rem_s   = 24'(num_s % den_s);
   assign exp_a_s = {2'b00, a_r.exp} - 10'd127;
   assign exp_b_s = {2'b00, b_r.exp} - 10'd127;

   // Normalise the raw product or quotient by at most one bit for rounding.
   always_comb begin
      if (!op_r) begin
         if (prod_s[47]) begin
            rp_mant_s   = prod_s[47:24];
            rp_guard_s  = prod_s[23];
            rp_sticky_s = |prod_s[22:0];
            rp_exp_s    = exp_a_s + exp_b_s + 10'sd1;
         end else begin
            rp_mant_s   = prod_s[46:23];
            rp_guard_s  = prod_s[22];
            rp_sticky_s = |prod_s[21:0];
            rp_exp_s    = exp_a_s + exp_b_s;
         end
      end else begin
         if (quo_s[26]) begin
            rp_mant_s   = quo_s[26:3];
            rp_guard_s  = quo_s[2];
            rp_sticky_s = (|quo_s[1:0]) | (|rem_s);
            rp_exp_s    = exp_a_s - exp_b_s;
         end else begin
            rp_mant_s   = quo_s[25:2];
            rp_guard_s  = quo_s[1];
            rp_sticky_s = quo_s[0] | (|rem_s);
            rp_exp_s    = exp_a_s - exp_b_s - 10'sd1;
         end
      end
   end

   fp_round_pack u_round_pack (
      .sign      (sign_s),
      .exp_unb   (rp_exp_s),
      .mant      (rp_mant_s),
      .guard     (rp_guard_s),
      .sticky    (rp_sticky_s),
      .res       (rp_res_s),
      .overflow  (rp_ovf_s),
      .underflow (rp_unf_s)
   );

   // Special-operand priority: NaN/invalid, div-by-zero, inf/zero, arithmetic.
   always_comb begin
      res_s = rp_res_s;
      ovf_s = 1'b0;
      unf_s = 1'b0;
      inv_s = 1'b0;
      dz_s  = 1'b0;
      if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN)) begin
         res_s = QNAN;
         inv_s = 1'b1;
      end else if (!op_r && (((cls_a_s == CLS_INF) && (cls_b_s == CLS_ZERO)) ||
                             ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_INF)))) begin
         res_s = QNAN;
         inv_s = 1'b1;
      end else if (op_r && (((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_ZERO)) ||
                            ((cls_a_s == CLS_INF) && (cls_b_s == CLS_INF)))) begin
         res_s = QNAN;
         inv_s = 1'b1;
      end else if (op_r && (cls_a_s == CLS_NORM) && (cls_b_s == CLS_ZERO)) begin
         res_s = sign_s ? NEG_INF : POS_INF;
         dz_s  = 1'b1;
      end else if (cls_a_s == CLS_INF) begin
         res_s = sign_s ? NEG_INF : POS_INF;
      end else if (cls_b_s == CLS_INF) begin
         // Only reachable as mul finite-nonzero*inf or div finite/inf.
         res_s = op_r ? {sign_s, 31'd0} : (sign_s ? NEG_INF : POS_INF);
      end else if ((cls_a_s == CLS_ZERO) || (cls_b_s == CLS_ZERO)) begin
         res_s = {sign_s, 31'd0};
      end else begin
         res_s = rp_res_s;
         ovf_s = rp_ovf_s;
         unf_s = rp_unf_s;
      end
   end

   // Output stage: result and flags are qualified by the stage valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= 32'd0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         out_valid <= v_r;
         if (v_r) begin
            result    <= res_s;
            overflow  <= ovf_s;
            underflow <= unf_s;
            invalid   <= inv_s;
            div_zero  <= dz_s;
         end else begin
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            div_zero  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_div.sv
// Scoreboard bench for mul_div: directed special cases, random normal operands
// against a real-arithmetic model, and random mid-stream resets.
module tb_mul_div;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;   // {overflow, underflow, invalid, div_zero}
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_sel;
   logic        in_valid;
   logic [31:0] result;
   logic        out_valid;
   logic        overflow;
   logic        underflow;
   logic        invalid;
   logic        div_zero;

   exp_t        sb_q[$];
   logic [1:0]  vpipe = 2'b00;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mul_div #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sel    (op_sel),
      .in_valid  (in_valid),
      .result    (result),
      .out_valid (out_valid),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid),
      .div_zero  (div_zero)
   );

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Exact double result rounded once more to binary32 (RNE, flush-to-zero).
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
      real         rr;
      logic [63:0] d;
      int          e;
      logic [24:0] m;
      logic        g;
      logic        s;
      exp_t        r;
      rr = op ? (f2r(a) / f2r(b)) : (f2r(a) * f2r(b));
      d  = $realtobits(rr);
      e  = int'(d[62:52]) - 896;
      m  = {2'b01, d[51:29]};
      g  = d[28];
      s  = |d[27:0];
      if (g && (s || m[0])) m = m + 25'd1;
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e >= 255)    r = '{res: {d[63], 8'hFF, 23'd0}, flg: 4'b1000};
      else if (e < 1)  r = '{res: {d[63], 31'd0}, flg: 4'b0100};
      else             r = '{res: {d[63], e[7:0], m[22:0]}, flg: 4'b0000};
      return r;
   endfunction

   function automatic logic [31:0] rnd_norm();
      logic [31:0] f;
      logic [7:0]  e;
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
      f = {1'($urandom_range(0, 1)), e, 23'($urandom())};
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
   endtask

   // One clock: drive at negedge, model the 2-deep valid pipe, compare at next negedge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic r, input exp_t e, input string tag);
      exp_t got;
      in_valid = v;
      op_a     = a;
      op_b     = b;
      op_sel   = op;
      rst      = r;
      if (v && !r) sb_q.push_back(e);
      @(posedge clk);
      if (r) begin
         sb_q.delete();
         vpipe = 2'b00;
      end else begin
         vpipe = {vpipe[0], v};
      end
      @(negedge clk);
      check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, vpipe[1]});
      if (r) begin
         check({tag, " reset result"}, result, 32'd0);
         check({tag, " reset flags"}, {28'd0, overflow, underflow, invalid, div_zero}, 32'd0);
      end else if (vpipe[1]) begin
         got = sb_q.pop_front();
         check({tag, " result"}, result, got.res);
         check({tag, " flags"}, {28'd0, overflow, underflow, invalid, div_zero}, {28'd0, got.flg});
      end else begin
         check({tag, " idle flags"}, {28'd0, overflow, underflow, invalid, div_zero}, 32'd0);
      end
   endtask

   task automatic dop(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] res, input logic [3:0] flg);
      cycle(1'b1, a, b, op, 1'b0, '{res: res, flg: flg}, tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '{res: 32'd0, flg: 4'd0}, tag);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic        v;
      logic        r;

      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '{res: 32'd0, flg: 4'd0}, "rst0");
      cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1, '{res: 32'd0, flg: 4'd0}, "rst_vld");
      idle("post_rst");

      dop("mul_max_ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b1000);
      dop("mul_negmax_ovf",32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'h7F80_0000, 4'b1000);
      dop("div_max_one",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h3F80_0000, 4'b0000);
      dop("div_negmin_one",32'h8080_0000, 32'h8080_0000, 1'b1, 32'h3F80_0000, 4'b0000);
      dop("mul_min_unf",   32'h0080_0000, 32'h0080_0000, 1'b0, 32'h0000_0000, 4'b0100);
      dop("mul_subnorm",   32'h0000_00FF, 32'h0000_00FF, 1'b0, 32'h0000_0000, 4'b0000);
      dop("mul_inf_zero",  32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 4'b0010);
      dop("div_by_zero",   32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 4'b0001);
      dop("div_zero_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 4'b0010);
      dop("mul_nan",       32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0010);
      dop("div_nan",       32'h3F80_0000, 32'h7FA0_0000, 1'b1, 32'h7FC0_0000, 4'b0010);
      dop("div_inf_inf",   32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, 4'b0010);
      idle("gap");
      dop("mul_2x3",       32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40C0_0000, 4'b0000);
      dop("div_1by3",      32'h3F80_0000, 32'h4040_0000, 1'b1, 32'h3EAA_AAAB, 4'b0000);
      dop("mul_ninf_fin",  32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 4'b0000);
      dop("div_inf_fin",   32'h7F80_0000, 32'hC000_0000, 1'b1, 32'hFF80_0000, 4'b0000);
      dop("div_fin_ninf",  32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h8000_0000, 4'b0000);
      dop("mul_nzero",     32'h8000_0000, 32'h3F80_0000, 1'b0, 32'h8000_0000, 4'b0000);
      dop("div_zero_fin",  32'h0000_0000, 32'hC040_0000, 1'b1, 32'h8000_0000, 4'b0000);
      dop("mul_subn_norm", 32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h0000_0000, 4'b0000);
      idle("drain0");
      idle("drain1");

      for (int i = 0; i < 200; i++) begin
         a  = rnd_norm();
         b  = rnd_norm();
         op = 1'($urandom_range(0, 1));
         v  = ($urandom_range(0, 7) != 0);
         cycle(v, a, b, op, 1'b0, model(a, b, op), op ? "rnd_div" : "rnd_mul");
      end
      idle("drain2");
      idle("drain3");

      for (int i = 0; i < 120; i++) begin
         a  = rnd_norm();
         b  = rnd_norm();
         op = 1'($urandom_range(0, 1));
         v  = ($urandom_range(0, 5) != 0);
         r  = ($urandom_range(0, 9) == 0);
         cycle(v, a, b, op, r, model(a, b, op), r ? "mid_rst" : "rst_stream");
      end
      idle("drain4");
      idle("drain5");
      idle("drain6");
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_div.md
MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 Port clk, input, 1: the single clock; every state element updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port op_a, input, 32: operand A, binary32.
REQ-005 Port op_b, input, 32: operand B, binary32.
REQ-006 Port op_sel, input, 1: 0 = multiply (A*B), 1 = divide (A/B).
REQ-007 Port in_valid, input, 1: operands and op_sel are valid this cycle.
REQ-008 Port result, output, 32: binary32 result, registered.
REQ-009 Port out_valid, output, 1: result and flags are valid this cycle.
REQ-010 Ports overflow, underflow, invalid, div_zero, output, 1 each: exception flags, aligned with result.

Function
REQ-011 Pipeline fixed at 2 cycles: inputs are registered on the in_valid edge; result, flags and out_valid appear exactly 2 rising edges later.
REQ-012 No backpressure: a new operation may be accepted every cycle, and out_valid mirrors in_valid delayed by 2.
REQ-013 Result sign = sign(A) XOR sign(B) for every non-NaN result.
REQ-014 Multiply: 24x24 mantissa product, exponent eA+eB-127, normalised by at most 1 bit.
REQ-015 Divide: quotient of mantissas carrying at least 26 bits (24 + guard + sticky), exponent eA-eB+127, normalised by at most 1 bit.
REQ-016 Rounding is round-to-nearest-even, using guard and sticky bits; a mantissa carry on rounding re-normalises and increments the exponent.
REQ-017 Subnormal inputs (exp=0, frac!=0) are flushed to signed zero before the operation.
REQ-018 A result exponent below 1 after rounding gives signed zero and underflow=1 (flush-to-zero, no subnormal output).
REQ-019 A result exponent of 255 or more gives signed infinity (0x7F800000 / 0xFF800000) and overflow=1.
REQ-020 Any NaN input gives canonical quiet NaN 0x7FC00000 with invalid=1.
REQ-021 Mul inf*0 and Div 0/0 or inf/inf give 0x7FC00000 with invalid=1.
REQ-022 Mul inf*finite-nonzero gives signed inf, with no flag.
REQ-023 Div inf/finite gives signed inf; finite/inf gives signed zero.
REQ-024 Div finite-nonzero/0 gives signed inf with div_zero=1.
REQ-025 Zero*finite and 0/finite-nonzero give signed zero, with no flag.
REQ-026 Flags are zero whenever out_valid=0.
REQ-027 The special-case priority is fixed: NaN/invalid, then div_zero, then inf/zero operands, then the overflow/underflow arithmetic path.

Reset
REQ-028 While rst=1 at a rising edge, all pipeline registers clear, giving result=0, out_valid=0 and all flags=0 from the next cycle.
REQ-029 rst asserted mid-operation discards every in-flight operation, and no out_valid is produced for it.
REQ-030 in_valid sampled in the same cycle as rst=1 is ignored.
REQ-031 The first operation is accepted in the cycle after rst deasserts.

Structure
REQ-032 Package mul_div_pkg holds the binary32 field widths, the bias 127, the constants QNAN=0x7FC00000, POS_INF=0x7F800000 and NEG_INF=0xFF800000, and a packed struct {sign, exp[7:0], frac[22:0]}.
REQ-033 One sub-module, fp_round_pack, is shared by multiply and divide; it takes sign, unbiased exponent and mantissa with guard/sticky, and returns the packed result plus overflow/underflow.

Verification
REQ-034 Mul 0x7F7FFFFF*0x7F7FFFFF -> 0x7F800000, overflow=1; the same with 0xFF7FFFFF operands -> 0x7F800000, overflow=1.
REQ-035 Div 0x7F7FFFFF/0x7F7FFFFF -> 0x3F800000; Div 0x80800000/0x80800000 -> 0x3F800000; all flags 0.
REQ-036 Mul 0x00800000*0x00800000 -> 0x00000000, underflow=1; Mul 0x000000FF*0x000000FF (subnormals) -> 0x00000000.
REQ-037 Mul 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1; Div 0x3F800000/0x00000000 -> 0x7F800000, div_zero=1; Div 0/0 -> 0x7FC00000, invalid=1.
REQ-038 Any NaN operand (e.g. 0x7FA00000) with either op_sel -> 0x7FC00000, invalid=1.
REQ-039 Random normal operands in both modes, compared against a real-arithmetic model with flush-to-zero and RNE.
REQ-040 Reset pulsed at random cycles mid-stream: no out_valid for operations in flight, outputs zero the cycle after reset, and the next operation has correct 2-cycle latency.
